// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with a 2-bit saturating counter per entry.
// The IF-stage lookup is combinational from registered table state, and ID-stage
// resolved outcomes train the table at the rising edge.
// Optional feature: define BTB_STATS_EN to add lookup/update/mispredict counters.
module branch_predictor #(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = 6,
  parameter int TAG_W   = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        btb_en,
  output logic        jump,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_mispred,
  input  logic        flush
`ifdef BTB_STATS_EN
  ,
  output logic [31:0] stat_lookups,
  output logic [31:0] stat_updates,
  output logic [31:0] stat_mispred
`endif
);

  // Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
  localparam logic [1:0] CTR_RESET = 2'b01;
  localparam logic [1:0] CTR_ALLOC = 2'b10;

  // Saturating increment: a strong-taken counter stays strong-taken.
  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'd1;
  endfunction

  // Saturating decrement: a strong-not-taken counter stays strong-not-taken.
  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  // Control state (reset) and data storage (no reset).
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [1:0]         ctr_q [ENTRIES];
  logic [1:0]         ctr_d [ENTRIES];
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [31:0]        target_q [ENTRIES];

  // Lookup side fields; the two byte-offset bits of the PC are ignored.
  logic [IDX_W-1:0]   lk_idx;
  logic [TAG_W-1:0]   lk_tag;
  logic               lk_hit;

  // Update side fields and the single write port into tag/target storage.
  logic [IDX_W-1:0]   up_idx;
  logic [TAG_W-1:0]   up_tag;
  logic               up_hit;
  logic               upd_accept;
  logic               tag_we;
  logic               tgt_we;
  logic [TAG_W-1:0]   tag_d;
  logic [31:0]        target_d;

  logic               unused_bits;

  assign lk_idx     = if_pc[IDX_W+1:2];
  assign lk_tag     = if_pc[31:IDX_W+2];
  assign up_idx     = upd_pc[IDX_W+1:2];
  assign up_tag     = upd_pc[31:IDX_W+2];
  assign upd_accept = upd_valid & ~flush;

`ifdef BTB_STATS_EN
  assign unused_bits = ^{if_pc[1:0], upd_pc[1:0]};
`else
  assign unused_bits = ^{if_pc[1:0], upd_pc[1:0], upd_mispred};
`endif

  // IF-stage lookup: reads registered state only, so a same-cycle update is not bypassed.
  always_comb begin
    lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    btb_en      = lk_hit;
    jump        = lk_hit & ctr_q[lk_idx][1];
    pred_target = lk_hit ? target_q[lk_idx] : 32'h0;
  end

  // Next-state for valid/counter bits and write enables for tag/target storage.
  always_comb begin
    valid_d  = valid_q;
    for (int i = 0; i < ENTRIES; i++) begin
      ctr_d[i] = ctr_q[i];
    end
    tag_we   = 1'b0;
    tgt_we   = 1'b0;
    tag_d    = up_tag;
    target_d = upd_target;
    up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    if (flush) begin
      // Flush wins over a simultaneous update, which is simply dropped.
      valid_d = '0;
    end else if (upd_valid) begin
      if (up_hit) begin
        if (upd_taken) begin
          ctr_d[up_idx] = ctr_inc(ctr_q[up_idx]);
          tgt_we        = 1'b1;
        end else begin
          ctr_d[up_idx] = ctr_dec(ctr_q[up_idx]);
        end
      end else if (upd_taken) begin
        // Miss on a taken branch: overwrite whatever lives at this index.
        valid_d[up_idx] = 1'b1;
        ctr_d[up_idx]   = CTR_ALLOC;
        tag_we          = 1'b1;
        tgt_we          = 1'b1;
      end
    end
  end

  // Control state: async reset invalidates every entry and sets counters weak-NT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= CTR_RESET;
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= ctr_d[i];
      end
    end
  end

  // Tag/target storage: never read while its valid bit is clear, so it needs no reset.
  always_ff @(posedge clk) begin
    if (tag_we) begin
      tag_q[up_idx] <= tag_d;
    end
    if (tgt_we) begin
      target_q[up_idx] <= target_d;
    end
  end

`ifdef BTB_STATS_EN
  logic [31:0] stat_lookups_q, stat_lookups_d;
  logic [31:0] stat_updates_q, stat_updates_d;
  logic [31:0] stat_mispred_q, stat_mispred_d;

  // Statistics next-state: free-running lookups, accepted updates, accepted mispredicts.
  always_comb begin
    stat_lookups_d = stat_lookups_q + 32'd1;
    stat_updates_d = stat_updates_q;
    stat_mispred_d = stat_mispred_q;
    if (upd_accept) begin
      stat_updates_d = stat_updates_q + 32'd1;
      if (upd_mispred) begin
        stat_mispred_d = stat_mispred_q + 32'd1;
      end
    end
  end

  // Statistics registers: wrap modulo 2^32, cleared by reset only (flush leaves them alone).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_lookups_q <= '0;
      stat_updates_q <= '0;
      stat_mispred_q <= '0;
    end else begin
      stat_lookups_q <= stat_lookups_d;
      stat_updates_q <= stat_updates_d;
      stat_mispred_q <= stat_mispred_d;
    end
  end

  assign stat_lookups = stat_lookups_q;
  assign stat_updates = stat_updates_q;
  assign stat_mispred = stat_mispred_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed vector table, hand-written reset and
// statistics sequences, then randomized traffic against a behavioural model.
module tb_branch_predictor;

  localparam int ENTRIES = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        btb_en;
  logic        jump;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispred;
  logic        flush;
`ifdef BTB_STATS_EN
  logic [31:0] stat_lookups;
  logic [31:0] stat_updates;
  logic [31:0] stat_mispred;
`endif

  branch_predictor dut (
    .clk         (clk),
    .rst         (rst),
    .if_pc       (if_pc),
    .btb_en      (btb_en),
    .jump        (jump),
    .pred_target (pred_target),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target),
    .upd_mispred (upd_mispred),
    .flush       (flush)
`ifdef BTB_STATS_EN
    ,
    .stat_lookups(stat_lookups),
    .stat_updates(stat_updates),
    .stat_mispred(stat_mispred)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // ---------------- behavioural reference model ----------------
  // Each entry remembers the full word address of the branch that owns it;
  // a lookup hits when that address equals the fetch word address.
  bit          m_valid [ENTRIES];
  int unsigned m_word  [ENTRIES];
  int unsigned m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  int unsigned m_lookups, m_updates, m_mispred;

  function automatic int slot(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0;
      m_ctr[i]   = 1;
    end
    m_lookups = 0; m_updates = 0; m_mispred = 0;
  endtask

  task automatic m_lookup(input logic [31:0] pc, output logic en, output logic jp,
                          output logic [31:0] tgt);
    int s;
    s   = slot(pc);
    en  = m_valid[s] && (m_word[s] == (pc >> 2));
    jp  = en && (m_ctr[s] >= 2);
    tgt = en ? m_tgt[s] : 32'h0;
  endtask

  task automatic m_update(input logic uv, input logic [31:0] upc, input logic ut,
                          input logic [31:0] utgt, input logic mp, input logic fl);
    int s;
    m_lookups++;
    if (fl) begin
      for (int i = 0; i < ENTRIES; i++) m_valid[i] = 0;
      return;
    end
    if (!uv) return;
    m_updates++;
    if (mp) m_mispred++;
    s = slot(upc);
    if (m_valid[s] && m_word[s] == (upc >> 2)) begin
      if (ut) begin
        if (m_ctr[s] < 3) m_ctr[s]++;
        m_tgt[s] = utgt;
      end else if (m_ctr[s] > 0) m_ctr[s]--;
    end else if (ut) begin
      m_valid[s] = 1; m_word[s] = upc >> 2; m_tgt[s] = utgt; m_ctr[s] = 2;
    end
  endtask

  // One cycle checked against the model: drive, check pre-edge lookup, train model, clock.
  task automatic cyc(input logic uv, input logic [31:0] upc, input logic ut,
                     input logic [31:0] utgt, input logic mp, input logic fl,
                     input logic [31:0] ipc, input string nm);
    logic e_en, e_jp;
    logic [31:0] e_tgt;
    upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utgt;
    upd_mispred = mp; flush = fl; if_pc = ipc;
    #1;
    m_lookup(ipc, e_en, e_jp, e_tgt);
    chk({nm, "_btb_en"}, {31'b0, btb_en}, {31'b0, e_en});
    chk({nm, "_jump"}, {31'b0, jump}, {31'b0, e_jp});
    chk({nm, "_target"}, pred_target, e_tgt);
    m_update(uv, upc, ut, utgt, mp, fl);
    @(posedge clk); #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    upd_valid = 0; flush = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic        fl;
    logic [31:0] ipc;
    logic        en;
    logic        jp;
    logic [31:0] tgt;
  } vec_t;

  vec_t vq[$];

  task automatic row(input logic uv, input logic [31:0] upc, input logic ut,
                     input logic [31:0] utgt, input logic fl, input logic [31:0] ipc,
                     input logic en, input logic jp, input logic [31:0] tgt);
    vec_t v;
    v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt; v.fl = fl;
    v.ipc = ipc; v.en = en; v.jp = jp; v.tgt = tgt;
    vq.push_back(v);
  endtask

  function automatic logic [31:0] rnd_pc();
    logic [31:0] p;
    p = 32'h1000 + (32'($urandom_range(0, 3)) << 2)
        + 32'($urandom_range(0, 2)) * (4 * ENTRIES);
    if ($urandom_range(0, 7) == 0) p[31] = 1'b1;
    return p;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; if_pc = 32'h100;
    upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_target = 0; upd_mispred = 0; flush = 0;

    // Expected lookup values are the pre-edge contents of each cycle (no bypass).
    row(0, 32'h000, 0, 32'h000, 0, 32'h100, 0, 0, 32'h000); // after reset: empty
    row(1, 32'h100, 1, 32'h200, 0, 32'h100, 0, 0, 32'h000); // allocate, not visible yet
    row(0, 32'h000, 0, 32'h000, 0, 32'h100, 1, 1, 32'h200); // ctr 10
    row(1, 32'h100, 0, 32'h000, 0, 32'h100, 1, 1, 32'h200); // 10 -> 01
    row(1, 32'h100, 0, 32'h000, 0, 32'h100, 1, 0, 32'h200); // 01 -> 00
    row(1, 32'h100, 0, 32'h000, 0, 32'h100, 1, 0, 32'h200); // 00 stays 00
    row(1, 32'h100, 1, 32'h200, 0, 32'h100, 1, 0, 32'h200); // 00 -> 01
    row(1, 32'h100, 1, 32'h204, 0, 32'h100, 1, 0, 32'h200); // 01 -> 10, new target
    row(0, 32'h000, 0, 32'h000, 0, 32'h100, 1, 1, 32'h204);
    row(1, 32'h100, 1, 32'h204, 0, 32'h100, 1, 1, 32'h204); // 10 -> 11
    row(1, 32'h100, 1, 32'h208, 0, 32'h100, 1, 1, 32'h204); // 11 stays 11
    row(1, 32'h100, 0, 32'h000, 0, 32'h100, 1, 1, 32'h208); // 11 -> 10
    row(1, 32'h100, 0, 32'h000, 0, 32'h100, 1, 1, 32'h208); // 10 -> 01
    row(0, 32'h000, 0, 32'h000, 0, 32'h100, 1, 0, 32'h208);
    row(1, 32'h200, 1, 32'h300, 0, 32'h200, 0, 0, 32'h000); // alias replaces index 0
    row(0, 32'h000, 0, 32'h000, 0, 32'h100, 0, 0, 32'h000);
    row(0, 32'h000, 0, 32'h000, 0, 32'h200, 1, 1, 32'h300);
    row(1, 32'h104, 0, 32'h000, 0, 32'h104, 0, 0, 32'h000); // miss not-taken
    row(0, 32'h000, 0, 32'h000, 0, 32'h104, 0, 0, 32'h000); // nothing allocated
    row(0, 32'h000, 0, 32'h000, 0, 32'h202, 1, 1, 32'h300); // pc[1:0] ignored
    row(0, 32'h000, 0, 32'h000, 0, 32'h80000200, 0, 0, 32'h000); // top tag bit differs
    row(1, 32'h104, 1, 32'h400, 1, 32'h200, 1, 1, 32'h300); // flush + update
    row(0, 32'h000, 0, 32'h000, 0, 32'h200, 0, 0, 32'h000); // flushed
    row(0, 32'h000, 0, 32'h000, 0, 32'h104, 0, 0, 32'h000); // update dropped
    row(1, 32'h100, 1, 32'h500, 0, 32'h100, 0, 0, 32'h000);
    row(0, 32'h000, 0, 32'h000, 0, 32'h100, 1, 1, 32'h500);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      upd_valid = vq[i].uv; upd_pc = vq[i].upc; upd_taken = vq[i].ut;
      upd_target = vq[i].utgt; flush = vq[i].fl; if_pc = vq[i].ipc; upd_mispred = 0;
      #1;
      chk($sformatf("vec%0d_btb_en", i), {31'b0, btb_en}, {31'b0, vq[i].en});
      chk($sformatf("vec%0d_jump", i), {31'b0, jump}, {31'b0, vq[i].jp});
      chk($sformatf("vec%0d_target", i), pred_target, vq[i].tgt);
      @(posedge clk); #1;
    end

    // Async reset between edges clears outputs with no clock edge.
    upd_valid = 0; flush = 0; if_pc = 32'h100;
    #1 chk("pre_rst_hit", {31'b0, btb_en}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_btb_en", {31'b0, btb_en}, 32'd0);
    chk("async_rst_jump", {31'b0, jump}, 32'd0);
    chk("async_rst_target", pred_target, 32'h0);

    // Reset held across an edge carrying a taken update: the update must not land.
    @(posedge clk); #1;
    rst = 1'b0;
    upd_valid = 1; upd_pc = 32'h100; upd_taken = 1; upd_target = 32'h600;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; upd_valid = 0;
    #1 chk("rst_mid_update_btb_en", {31'b0, btb_en}, 32'd0);
    @(posedge clk); #1;

    // Statistics sequence: 10 accepted updates (3 mispredicts), one dropped by flush.
    reset_dut();
    for (int i = 0; i < 10; i++)
      cyc(1, 32'h2000 + 32'(i) * 4, 1'(i % 2), 32'h3000 + 32'(i), 1'(i < 3), 0,
          32'h2000, "stats_upd");
    cyc(1, 32'h2000, 1, 32'h3000, 1, 1, 32'h2000, "stats_flush");
    cyc(0, 32'h0, 0, 32'h0, 0, 0, 32'h2004, "stats_after_flush");
`ifdef BTB_STATS_EN
    chk("stat_updates", stat_updates, 32'd10);
    chk("stat_mispred", stat_mispred, 32'd3);
    chk("stat_lookups", stat_lookups, m_lookups);
`endif

    // Randomized traffic against the model.
    reset_dut();
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 9) < 7, rnd_pc(), $urandom_range(0, 9) < 6,
          $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)),
          $urandom_range(0, 31) == 0, rnd_pc() | 32'($urandom_range(0, 3)), "rand");
    end
`ifdef BTB_STATS_EN
    chk("rand_stat_updates", stat_updates, m_updates);
    chk("rand_stat_mispred", stat_mispred, m_mispred);
    chk("rand_stat_lookups", stat_lookups, m_lookups);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
